// File: rtl/fpmul_arbiter.sv
// ---------------------------------------------------------------------------
// fpmul_arbiter
//
// Purpose
//   Shares one combinational floating-point multiplier between two requesters.
//   A request is accepted in IDLE, its operands are registered, the product
//   is captured one cycle later (CALC), and the result is held (HOLD) until
//   the consumer takes it. Only one operation is in flight at a time.
//
// Number format (NB_TOTAL = NB_MANT + NB_EXP + 1 bits)
//   {sign, exponent[NB_EXP-1:0], mantissa[NB_MANT-1:0]}, exponent bias 7,
//   hidden leading one. Exponent 0 encodes zero, so any zero operand gives
//   a signed zero. There are no infinities or NaNs: exponent 15 is an ordinary
//   exponent. The product mantissa is truncated. Results too small for the
//   smallest exponent become signed zero. Results too large saturate to the
//   largest magnitude {sign, all-ones exponent, all-ones mantissa}.
//
// Configuration
//   FPMUL_ARB_ROUND_ROBIN_EN  defined   : with both requesters valid, grant
//                                         the one that did not win last
//                                         (LAST resets to 1, so 0 goes first).
//                             undefined : fixed priority, requester 0 wins.
//   A single valid requester is granted in either build.
//
// Handshakes
//   Every handshake is valid/ready: a transfer happens on a rising edge where
//   both are 1. READY never depends on anything the requester does in the
//   same cycle except its own VALID. A requester may drop VALID before it is
//   accepted. The consumer side is the same: RES_C/RES_ID are stable while
//   RES_VALID=1 and RES_READY=0.
//
// Ports
//   clk, rst_n               clock, synchronous active-low reset
//   REQ0_VALID/A/B, REQ0_READY   requester 0 operand channel
//   REQ1_VALID/A/B, REQ1_READY   requester 1 operand channel
//   RES_VALID, RES_C, RES_ID     result channel (product and issuer index)
//   RES_READY                    consumer accepts result
//   OP_CNT                       completed result handshakes, wraps 255 -> 0
//   dbg_state                    FSM state (0 IDLE, 1 CALC, 2 HOLD)
//   dbg_last                     arbitration pointer LAST
// ---------------------------------------------------------------------------

// Combinational multiplier core. It has no state of its own.
module fpmul_core #(
    parameter int NB_MANT = 8,
    parameter int NB_EXP  = 4,
    parameter int BIAS    = 7
) (
    input  logic [NB_MANT+NB_EXP:0] a,
    input  logic [NB_MANT+NB_EXP:0] b,
    output logic [NB_MANT+NB_EXP:0] c
);
    localparam int NB_TOTAL = NB_MANT + NB_EXP + 1;
    localparam int NB_PROD  = 2 * (NB_MANT + 1);
    // Two extra bits hold the sum of two exponents plus the normalise carry.
    localparam int NB_ESUM  = NB_EXP + 2;
    localparam logic [NB_ESUM-1:0] BIAS_W = NB_ESUM'(BIAS);
    // Largest biased sum that still fits the exponent field after unbiasing.
    localparam logic [NB_ESUM-1:0] EMAX_W = NB_ESUM'((1 << NB_EXP) - 1 + BIAS);

    logic                sign;
    logic [NB_EXP-1:0]   ea;
    logic [NB_EXP-1:0]   eb;
    logic [NB_MANT:0]    ma;
    logic [NB_MANT:0]    mb;
    logic [NB_PROD-1:0]  prod;
    logic                norm;
    logic [NB_MANT-1:0]  frac;
    logic [NB_ESUM-1:0]  esum;
    logic [NB_ESUM-1:0]  eres;

    always_comb begin
        sign = a[NB_TOTAL-1] ^ b[NB_TOTAL-1];
        ea   = a[NB_TOTAL-2 -: NB_EXP];
        eb   = b[NB_TOTAL-2 -: NB_EXP];
        ma   = {1'b1, a[NB_MANT-1:0]};
        mb   = {1'b1, b[NB_MANT-1:0]};
        prod = {{(NB_MANT+1){1'b0}}, ma} * {{(NB_MANT+1){1'b0}}, mb};

        // Two 1.x significands give a product in [1, 4). When it reaches 2
        // the top bit is set and the fraction is taken one place higher.
        norm = prod[NB_PROD-1];
        frac = norm ? prod[NB_PROD-2 -: NB_MANT] : prod[NB_PROD-3 -: NB_MANT];

        // Exponent arithmetic stays unsigned: sum of biased exponents plus
        // the carry, compared with the bias instead of subtracting first.
        esum = {2'b00, ea} + {2'b00, eb} + {{(NB_ESUM-1){1'b0}}, norm};
        eres = esum - BIAS_W;

        if ((ea == '0) || (eb == '0) || (esum <= BIAS_W)) begin
            c = {sign, {(NB_EXP+NB_MANT){1'b0}}};
        end else if (esum > EMAX_W) begin
            c = {sign, {(NB_EXP+NB_MANT){1'b1}}};
        end else begin
            c = {sign, eres[NB_EXP-1:0], frac};
        end
    end
endmodule

module fpmul_arbiter #(
    parameter int NB_MANT  = 8,
    parameter int NB_EXP   = 4,
    // Derived from the two above; do not override on its own.
    parameter int NB_TOTAL = NB_MANT + NB_EXP + 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                REQ0_VALID,
    input  logic [NB_TOTAL-1:0] REQ0_A,
    input  logic [NB_TOTAL-1:0] REQ0_B,
    output logic                REQ0_READY,
    input  logic                REQ1_VALID,
    input  logic [NB_TOTAL-1:0] REQ1_A,
    input  logic [NB_TOTAL-1:0] REQ1_B,
    output logic                REQ1_READY,
    output logic                RES_VALID,
    output logic [NB_TOTAL-1:0] RES_C,
    output logic                RES_ID,
    input  logic                RES_READY,
    output logic [7:0]          OP_CNT,
    output logic [1:0]          dbg_state,
    output logic                dbg_last
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;

    logic [NB_TOTAL-1:0] op_a;
    logic [NB_TOTAL-1:0] op_b;
    logic [NB_TOTAL-1:0] core_c;
    logic                id_reg;
    logic                last;

    logic                grant1;     // 1: requester 1 would win in IDLE
    logic                accept;
    logic                accept_id;

    // The single shared multiplier, fed only from the operand registers.
    fpmul_core #(
        .NB_MANT (NB_MANT),
        .NB_EXP  (NB_EXP),
        .BIAS    (7)
    ) u_core (
        .a (op_a),
        .b (op_b),
        .c (core_c)
    );

    // -----------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // -----------------------------------------------------------------
    // FSM: next state
    // -----------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept)    state_nxt = CALC;
            CALC:                state_nxt = HOLD;
            HOLD: if (RES_READY) state_nxt = IDLE;
            default:             state_nxt = IDLE;
        endcase
    end

    // -----------------------------------------------------------------
    // FSM: outputs (grant, READY, RES_VALID)
    // -----------------------------------------------------------------
    always_comb begin
        grant1     = 1'b0;
        REQ0_READY = 1'b0;
        REQ1_READY = 1'b0;
        RES_VALID  = 1'b0;

`ifdef FPMUL_ARB_ROUND_ROBIN_EN
        // Contention goes to whoever did not win the previous accept.
        if (REQ0_VALID && REQ1_VALID) begin
            grant1 = ~last;
        end else begin
            grant1 = REQ1_VALID;
        end
`else
        // Requester 0 always wins contention; LAST is only tracked.
        grant1 = REQ1_VALID && !REQ0_VALID;
`endif

        // READY is masked by rst_n so nothing looks accepted during reset,
        // even on the first reset cycle before the state register clears.
        if ((state == IDLE) && rst_n) begin
            REQ0_READY = REQ0_VALID && !grant1;
            REQ1_READY = REQ1_VALID &&  grant1;
        end

        RES_VALID = (state == HOLD);
    end

    // READY already includes VALID, so either READY high is an accept.
    assign accept    = REQ0_READY | REQ1_READY;
    assign accept_id = REQ1_READY;

    // -----------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a   <= '0;
            op_b   <= '0;
            id_reg <= 1'b0;
            last   <= 1'b1;
            RES_C  <= '0;
            OP_CNT <= 8'd0;
        end else begin
            if (accept) begin
                op_a   <= accept_id ? REQ1_A : REQ0_A;
                op_b   <= accept_id ? REQ1_B : REQ0_B;
                id_reg <= accept_id;
                last   <= accept_id;
            end
            if (state == CALC) begin
                RES_C <= core_c;
            end
            // Free-running count; natural 8-bit wrap is intended.
            if ((state == HOLD) && RES_READY) begin
                OP_CNT <= OP_CNT + 8'd1;
            end
        end
    end

    assign RES_ID    = id_reg;
    assign dbg_state = state;
    assign dbg_last  = last;

endmodule
